// File: rtl/audio_buffer_player_pkg.sv
// Shared audio buffer constants: RAM geometry, the end-of-data marker bit,
// the byte-decoding rule and the player state encoding.
package audio_buffer_player_pkg;

    localparam int unsigned BUFFER_ADDR_BITS   = 10;
    localparam int unsigned BUFFER_DATA_BITS   = 9;
    localparam int unsigned BUFFER_EOD_BIT     = 8;
    localparam int unsigned MONO_FRAME_BYTES   = 2;
    localparam int unsigned STEREO_FRAME_BYTES = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_READY,
        ST_WAIT_RELEASE
    } player_state_e;

    // Padding bytes written past the end of the file read back as silence.
    function automatic logic [7:0] buffer_byte(input logic [BUFFER_DATA_BITS-1:0] word);
        return word[BUFFER_EOD_BIT] ? 8'h00 : word[7:0];
    endfunction

endpackage

// File: rtl/audio_buffer_player_tick.sv
// Fractional clock divider: one-cycle tick_o at SAMPLE_RATE on average,
// free-running from reset.
module sample_rate_tick #(
    parameter int unsigned CLK_FREQ    = 50000000,
    parameter int unsigned SAMPLE_RATE = 44100
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    logic [31:0] acc;
    logic [32:0] sum;

    always_comb begin
        sum = {1'b0, acc} + 33'(SAMPLE_RATE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc    <= '0;
            tick_o <= 1'b0;
        end else if (sum >= 33'(CLK_FREQ)) begin
            acc    <= 32'(sum - 33'(CLK_FREQ));
            tick_o <= 1'b1;
        end else begin
            acc    <= sum[31:0];
            tick_o <= 1'b0;
        end
    end

endmodule

// File: rtl/audio_buffer_player.sv
// Buffer consumer: claims a filled buffer, assembles little-endian PCM frames
// from it and presents one frame per sample tick to the output stage.
module audio_buffer_player
    import audio_buffer_player_pkg::*;
#(
    parameter int unsigned CLK_FREQ         = 50000000,
    parameter int unsigned SAMPLE_RATE      = 44100,
    parameter int unsigned BUFFER_ADDR_BITS = audio_buffer_player_pkg::BUFFER_ADDR_BITS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic [BUFFER_ADDR_BITS-1:0] audio_buffer_addr_o,
    input  logic [BUFFER_DATA_BITS-1:0] audio_buffer_data_i,
    input  logic                        audio_buffer_filled_i,
    output logic                        audio_buffer_empty_o,
    input  logic [7:0]                  wav_info_audio_channels,
    output logic [15:0]                 sample_left_o,
    output logic [15:0]                 sample_right_o,
    output logic                        sample_strobe_o,
    output logic                        underrun_o,
    output logic                        playing_o
);

    player_state_e               state, state_next;
    logic [BUFFER_ADDR_BITS-1:0] addr, addr_next;
    logic [2:0]                  count, count_next;
    logic [3:0][7:0]             frame, frame_next;
    logic                        mono, mono_next;
    logic                        empty, empty_next;
    logic                        playing, playing_next;
    logic                        strobe, strobe_next;
    logic                        underrun, underrun_next;
    logic [15:0]                 left, left_next;
    logic [15:0]                 right, right_next;
    logic                        tick;
    logic [2:0]                  frame_bytes;
    logic [7:0]                  byte_in;

    sample_rate_tick #(
        .CLK_FREQ   (CLK_FREQ),
        .SAMPLE_RATE(SAMPLE_RATE)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick_o(tick)
    );

    assign frame_bytes = mono ? 3'(MONO_FRAME_BYTES) : 3'(STEREO_FRAME_BYTES);
    assign byte_in     = buffer_byte(audio_buffer_data_i);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            addr     <= '0;
            count    <= '0;
            frame    <= '0;
            mono     <= 1'b1;
            empty    <= 1'b1;
            playing  <= 1'b0;
            strobe   <= 1'b0;
            underrun <= 1'b0;
            left     <= '0;
            right    <= '0;
        end else begin
            state    <= state_next;
            addr     <= addr_next;
            count    <= count_next;
            frame    <= frame_next;
            mono     <= mono_next;
            empty    <= empty_next;
            playing  <= playing_next;
            strobe   <= strobe_next;
            underrun <= underrun_next;
            left     <= left_next;
            right    <= right_next;
        end
    end

    always_comb begin
        state_next    = state;
        addr_next     = addr;
        count_next    = count;
        frame_next    = frame;
        mono_next     = mono;
        empty_next    = empty;
        playing_next  = playing;
        strobe_next   = 1'b0;
        underrun_next = 1'b0;
        left_next     = left;
        right_next    = right;

        case (state)
            ST_IDLE: begin
                empty_next   = 1'b1;
                playing_next = 1'b0;
                if (audio_buffer_filled_i) begin
                    empty_next   = 1'b0;
                    playing_next = 1'b1;
                    addr_next    = '0;
                    count_next   = '0;
                    mono_next    = (wav_info_audio_channels == 8'd1);
                    state_next   = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // Data lags the address by one cycle, so byte count-1 lands now.
                if (count != 3'd0) begin
                    frame_next[2'(count - 3'd1)] = byte_in;
                end
                if (count == frame_bytes) begin
                    state_next = ST_READY;
                end else begin
                    addr_next  = addr + BUFFER_ADDR_BITS'(1);
                    count_next = count + 3'd1;
                end
            end
            ST_READY: begin
                if (tick) begin
                    if (addr == '0) begin
                        empty_next   = 1'b1;
                        playing_next = 1'b0;
                        state_next   = ST_WAIT_RELEASE;
                    end else begin
                        count_next = '0;
                        state_next = ST_FETCH;
                    end
                end
            end
            ST_WAIT_RELEASE: begin
                if (!audio_buffer_filled_i) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (tick) begin
            strobe_next = 1'b1;
            if (state == ST_READY) begin
                left_next  = {frame[1], frame[0]};
                right_next = mono ? {frame[1], frame[0]} : {frame[3], frame[2]};
            end else begin
                underrun_next = 1'b1;
                if (state != ST_FETCH) begin
                    left_next  = '0;
                    right_next = '0;
                end
            end
        end
    end

    // A stereo frame needs at least four bytes of buffer.
    always_ff @(posedge clk) begin
        if (rst_n && state == ST_IDLE && audio_buffer_filled_i) begin
            assert (wav_info_audio_channels == 8'd1 || BUFFER_ADDR_BITS >= 2);
        end
    end

    assign audio_buffer_addr_o  = addr;
    assign audio_buffer_empty_o = empty;
    assign sample_left_o        = left;
    assign sample_right_o       = right;
    assign sample_strobe_o      = strobe;
    assign underrun_o           = underrun;
    assign playing_o            = playing;

endmodule
